// File: rtl/b_dx_packer_213.sv
// Output packer for the (2,1,3) Viterbi decoder: packs Dx bits LSB-first into words and queues them in a show-ahead FIFO.
// Optional error tagging of words is enabled by defining B_DX_PACK_ERRTAG_EN.
module b_dx_packer_213 #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_BITS = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    Dx,
    input  logic                    oe,
    input  logic                    sync_error,
    output logic [WORD_W-1:0]       dout,
    output logic [$clog2(WORD_W):0] dout_nbits,
    output logic                    dout_last,
    output logic                    dout_err,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    overflow
);
    localparam int NB_W  = $clog2(WORD_W) + 1;
    localparam int FC_W  = $clog2(FRAME_BITS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = WORD_W + NB_W + 2;

    // CLOSE marks the shift register as holding an already-pushed word.
    typedef enum logic {ACCUM, CLOSE} state_e;

    state_e            state_q;
    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] word_d;
    logic [NB_W-1:0]   bit_cnt_q;
    logic [NB_W-1:0]   bit_cnt_d;
    logic [FC_W-1:0]   frame_cnt_q;
    logic [FC_W-1:0]   frame_cnt_d;
    logic              close_w;
    logic              last_w;
    logic              err_word;

    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              push;
    logic              pop;
    logic              full;
    logic [ENT_W-1:0]  head;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        word_d = (state_q == CLOSE) ? '0 : shift_q;
        for (int i = 0; i < WORD_W; i++) begin
            if (bit_cnt_q == NB_W'(i)) word_d[i] = Dx;
        end
        bit_cnt_d   = bit_cnt_q + 1'b1;
        frame_cnt_d = frame_cnt_q + 1'b1;
        last_w      = oe && (frame_cnt_d == FC_W'(FRAME_BITS));
        close_w     = oe && (last_w || (bit_cnt_d == NB_W'(WORD_W)));
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= CLOSE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
        end else if (oe) begin
            shift_q     <= word_d;
            frame_cnt_q <= last_w ? '0 : frame_cnt_d;
            if (close_w) begin
                state_q   <= CLOSE;
                bit_cnt_q <= '0;
            end else begin
                state_q   <= ACCUM;
                bit_cnt_q <= bit_cnt_d;
            end
        end
    end

`ifdef B_DX_PACK_ERRTAG_EN
    logic err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)          err_q <= 1'b0;
        else if (close_w)   err_q <= 1'b0;
        else if (sync_error) err_q <= 1'b1;
    end

    assign err_word = err_q | sync_error;
`else
    // Error tagging disabled: sync_error is deliberately ignored.
    assign err_word = 1'b0 & sync_error;
`endif

    assign full = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop  = (count_q != '0) && dout_ready;
    assign push = close_w && (!full || pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (close_w && !push) overflow_q <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; outputs are gated by dout_valid instead.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= {last_w, err_word, bit_cnt_d, word_d};
    end

    assign head       = mem_q[rd_ptr_q];
    assign dout_valid = (count_q != '0);
    assign dout       = dout_valid ? head[WORD_W-1:0] : '0;
    assign dout_nbits = dout_valid ? head[WORD_W +: NB_W] : '0;
    assign dout_err   = dout_valid & head[ENT_W-2];
    assign dout_last  = dout_valid & head[ENT_W-1];
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_b_dx_packer_213.sv
// Self-checking bench for b_dx_packer_213: a 64-bit-frame instance and a 12-bit-frame instance share stimulus.
module tb_b_dx_packer_213;
`ifdef B_DX_PACK_ERRTAG_EN
    localparam logic ERRTAG = 1'b1;
`else
    localparam logic ERRTAG = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       Dx = 1'b0;
    logic       oe = 1'b0;
    logic       sync_error = 1'b0;
    logic       dout_ready = 1'b0;

    logic [7:0] a_dout, b_dout;
    logic [3:0] a_nbits, b_nbits;
    logic       a_last, a_err, a_valid, a_ovf;
    logic       b_last, b_err, b_valid, b_ovf;

    int total = 0;
    int bad   = 0;

    b_dx_packer_213 #(.WORD_W(8), .FIFO_DEPTH(4), .FRAME_BITS(64)) dut_a (
        .clock(clock), .reset(reset), .Dx(Dx), .oe(oe), .sync_error(sync_error),
        .dout(a_dout), .dout_nbits(a_nbits), .dout_last(a_last), .dout_err(a_err),
        .dout_valid(a_valid), .dout_ready(dout_ready), .overflow(a_ovf)
    );

    b_dx_packer_213 #(.WORD_W(8), .FIFO_DEPTH(4), .FRAME_BITS(12)) dut_b (
        .clock(clock), .reset(reset), .Dx(Dx), .oe(oe), .sync_error(sync_error),
        .dout(b_dout), .dout_nbits(b_nbits), .dout_last(b_last), .dout_err(b_err),
        .dout_valid(b_valid), .dout_ready(dout_ready), .overflow(b_ovf)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] pat;
        logic       se;
        logic [7:0] exp_word;
        logic [3:0] exp_nbits;
        logic       exp_last;
        logic       exp_err;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; oe = 1'b0; sync_error = 1'b0; dout_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Sends n bits of pat LSB-first on consecutive cycles, ending on the negedge after the last sample.
    task automatic send_word(input logic [7:0] pat, input int n, input logic se, input logic pop_on_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            Dx = pat[i];
            oe = 1'b1;
            sync_error = se && (i == 3);
            if (pop_on_last && i == n - 1) dout_ready = 1'b1;
        end
        @(negedge clock);
        oe = 1'b0;
        Dx = 1'bz;
        sync_error = 1'b0;
        if (pop_on_last) dout_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] q_exp [4];
        logic [7:0] pats [8];

        pats[0] = 8'hA3; pats[1] = 8'h00; pats[2] = 8'hFF; pats[3] = 8'h81;
        pats[4] = 8'h3C; pats[5] = 8'h7E; pats[6] = 8'h01; pats[7] = 8'h80;
        for (int i = 0; i < 16; i++) begin
            vecs[i].pat       = (i < 8) ? 8'h55 : pats[i-8];
            vecs[i].se        = (i == 9);
            vecs[i].exp_word  = vecs[i].pat;
            vecs[i].exp_nbits = 4'd8;
            vecs[i].exp_last  = (i == 7) || (i == 15);
            vecs[i].exp_err   = ERRTAG && (i == 9);
        end

        // Reset state
        @(negedge clock);
        #1;
        check("rst_valid", a_valid, 0);
        check("rst_dout", a_dout, 0);
        check("rst_nbits", a_nbits, 0);
        check("rst_last", a_last, 0);
        check("rst_err", a_err, 0);
        check("rst_ovf", a_ovf, 0);
        @(negedge clock);
        reset = 1'b0;

        // Two full 64-bit frames through the table, consumer always ready
        dout_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_word(vecs[i].pat, 8, vecs[i].se, 1'b0);
            check($sformatf("tbl%0d_valid", i), a_valid, 1);
            check($sformatf("tbl%0d_word", i), a_dout, vecs[i].exp_word);
            check($sformatf("tbl%0d_nbits", i), a_nbits, vecs[i].exp_nbits);
            check($sformatf("tbl%0d_last", i), a_last, vecs[i].exp_last);
            check($sformatf("tbl%0d_err", i), a_err, vecs[i].exp_err);
        end
        @(negedge clock);
        check("tbl_drained", a_valid, 0);
        check("tbl_ovf", a_ovf, 0);

        // 12-bit frame: one full word then a partial last word
        do_reset();
        dout_ready = 1'b1;
        send_word(8'hFF, 8, 1'b0, 1'b0);
        check("f12_w0_word", b_dout, 8'hFF);
        check("f12_w0_nbits", b_nbits, 8);
        check("f12_w0_last", b_last, 0);
        check("f64_w0_word", a_dout, 8'hFF);
        send_word(8'hFF, 4, 1'b0, 1'b0);
        check("f12_w1_valid", b_valid, 1);
        check("f12_w1_word", b_dout, 8'h0F);
        check("f12_w1_nbits", b_nbits, 4);
        check("f12_w1_last", b_last, 1);
        check("f64_no_partial", a_valid, 0);

        // Consumer stalled: four words held, fifth dropped, then drained in order
        do_reset();
        q_exp[0] = 8'h11; q_exp[1] = 8'h22; q_exp[2] = 8'h33; q_exp[3] = 8'h44;
        for (int i = 0; i < 4; i++) send_word(q_exp[i], 8, 1'b0, 1'b0);
        check("full_ovf_before", a_ovf, 0);
        check("full_head", a_dout, 8'h11);
        send_word(8'h55, 8, 1'b0, 1'b0);
        check("drop_ovf", a_ovf, 1);
        check("drop_head_stable", a_dout, 8'h11);
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("drain%0d_valid", i), a_valid, 1);
            check($sformatf("drain%0d_word", i), a_dout, q_exp[i]);
            @(negedge clock);
        end
        check("drain_empty", a_valid, 0);
        check("drain_ovf_sticky", a_ovf, 1);

        // FIFO full, word closes on the same edge as a pop
        do_reset();
        q_exp[0] = 8'hA1; q_exp[1] = 8'hA2; q_exp[2] = 8'hA3; q_exp[3] = 8'hA4;
        for (int i = 0; i < 4; i++) send_word(q_exp[i], 8, 1'b0, 1'b0);
        send_word(8'hB5, 8, 1'b0, 1'b1);
        check("popush_ovf", a_ovf, 0);
        check("popush_head", a_dout, 8'hA2);
        dout_ready = 1'b1;
        q_exp[0] = 8'hA2; q_exp[1] = 8'hA3; q_exp[2] = 8'hA4; q_exp[3] = 8'hB5;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("popush_drain%0d", i), a_dout, q_exp[i]);
            @(negedge clock);
        end
        check("popush_empty", a_valid, 0);

        // Reset mid-word with two words queued
        do_reset();
        send_word(8'hC3, 8, 1'b0, 1'b0);
        send_word(8'h3C, 8, 1'b0, 1'b0);
        send_word(8'h1F, 5, 1'b0, 1'b0);
        check("pre_rst_valid", a_valid, 1);
        reset = 1'b1;
        #1;
        check("midrst_valid", a_valid, 0);
        check("midrst_dout", a_dout, 0);
        @(negedge clock);
        reset = 1'b0;
        dout_ready = 1'b1;
        send_word(8'h96, 8, 1'b0, 1'b0);
        check("fresh_valid", a_valid, 1);
        check("fresh_word", a_dout, 8'h96);
        check("fresh_nbits", a_nbits, 8);
        check("fresh_last", a_last, 0);
        @(negedge clock);
        check("fresh_no_stale", a_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
